// File: rtl/async_fifo_fwft_rd_if.sv
// Handshake bundle between the FIFO read port, the FWFT adapter and the downstream consumer.
// The master modport is the adapter's view; the slave modport is the surrounding environment.
interface async_fifo_fwft_rd_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_r_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        input  m_ready,
        input  cnt_clr,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output word_cnt
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        output m_ready,
        output cnt_clr,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  word_cnt
    );
endinterface

// File: rtl/async_fifo_fwft_rd.sv
// FWFT adapter for the read side of the async FIFO: a 2-entry skid buffer fed by credit-limited
// registered reads, presenting a valid/ready stream and a saturating delivered-word counter.
module async_fifo_fwft_rd #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                      clk_rd_i,
    input  logic                      rst_n_rd_i,
    async_fifo_fwft_rd_if.master      bus_io
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             inflight_q;
    logic             head_q;
    logic             tail_q;
    logic [WIDTH-1:0] buf_q [2];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pop;
    logic             capture;
    logic             rd_en;
    logic [2:0]       occ;

    // A read is only issued when a slot is guaranteed free by the time its data arrives,
    // counting the word already in flight and any pop happening this cycle.
    always_comb begin
        pop     = (state_q != EMPTY) && bus_io.m_ready;
        capture = inflight_q;
        occ     = {1'b0, state_q} + {2'b00, inflight_q};
        rd_en   = rst_n_rd_i && !bus_io.fifo_empty && ((occ - {2'b00, pop}) < 3'd2);

        state_d = state_q;
        case ({capture, pop})
            2'b10: begin
                case (state_q)
                    EMPTY:   state_d = ONE;
                    default: state_d = TWO;
                endcase
            end
            2'b01: begin
                case (state_q)
                    TWO:     state_d = ONE;
                    default: state_d = EMPTY;
                endcase
            end
            default: state_d = state_q;
        endcase

        cnt_d = cnt_q;
        if (bus_io.cnt_clr) begin
            cnt_d = '0;
        end else if (pop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_rd_i or negedge rst_n_rd_i) begin
        if (!rst_n_rd_i) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            cnt_q      <= cnt_d;
            if (capture) begin
                buf_q[tail_q] <= bus_io.fifo_r_data;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    assign bus_io.fifo_rd_en = rd_en;
    assign bus_io.m_valid    = (state_q != EMPTY);
    assign bus_io.m_data     = buf_q[head_q];
    assign bus_io.word_cnt   = cnt_q;

endmodule

// File: tb/tb_async_fifo_fwft_rd.sv
// Bench for async_fifo_fwft_rd: a queue-based FIFO source and adapter model checked every cycle,
// with a second instance at CNT_W=4 sharing the stimulus to exercise counter saturation.
module tb_async_fifo_fwft_rd;

    logic clk = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    async_fifo_fwft_rd_if #(.WIDTH(32), .CNT_W(16)) busA ();
    async_fifo_fwft_rd_if #(.WIDTH(32), .CNT_W(4))  busB ();

    assign busB.fifo_empty  = busA.fifo_empty;
    assign busB.fifo_r_data = busA.fifo_r_data;
    assign busB.m_ready     = busA.m_ready;
    assign busB.cnt_clr     = busA.cnt_clr;

    async_fifo_fwft_rd #(.WIDTH(32), .CNT_W(16)) dutA (
        .clk_rd_i   (clk),
        .rst_n_rd_i (rstN),
        .bus_io     (busA)
    );

    async_fifo_fwft_rd #(.WIDTH(32), .CNT_W(4)) dutB (
        .clk_rd_i   (clk),
        .rst_n_rd_i (rstN),
        .bus_io     (busB)
    );

    logic [31:0] srcQ [$];
    logic [31:0] advQ [$];
    bit          mInflight = 1'b0;
    int          cntA = 0;
    int          cntB = 0;
    bit          planPop = 1'b0;
    bit          planRd = 1'b0;
    bit          planClr = 1'b0;

    int          readyMode = 1;
    bit          gapMode = 1'b0;
    bit          gapPhase = 1'b0;
    bit          clrReq = 1'b0;

    int          checkCnt = 0;
    int          passCnt = 0;

    int          cycNo = 0;
    int          rdPulses = 0;
    int          firstRdCyc = -1;
    int          firstValidCyc = -1;
    logic [31:0] firstValidData = '0;
    int          runLen = 0;
    int          maxRun = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model view: advQ holds words read from the FIFO in order; the last one is still
    // in flight when mInflight is set, everything before it sits in the output buffer.
    task automatic checkOutput();
        int held;
        bit expValid;
        bit expRd;
        bit pop;
        held     = advQ.size() - int'(mInflight);
        expValid = (held > 0);
        pop      = expValid && (busA.m_ready === 1'b1);
        expRd    = (rstN === 1'b1) && (busA.fifo_empty === 1'b0) &&
                   ((held + int'(mInflight) - int'(pop)) < 2);

        check("m_valid", 32'(busA.m_valid), 32'(expValid));
        check("fifo_rd_en", 32'(busA.fifo_rd_en), 32'(expRd));
        check("rd_while_empty", 32'(busA.fifo_rd_en & busA.fifo_empty), 32'd0);
        if (expValid) begin
            check("m_data", busA.m_data, advQ[0]);
        end else if (rstN !== 1'b1) begin
            check("m_data_reset", busA.m_data, 32'd0);
        end
        check("word_cnt", 32'(busA.word_cnt), 32'(cntA));
        check("word_cnt_sat4", 32'(busB.word_cnt), 32'(cntB));

        if (busA.fifo_rd_en === 1'b1) begin
            rdPulses++;
            if (firstRdCyc < 0) firstRdCyc = cycNo;
        end
        if (busA.m_valid === 1'b1) begin
            if (firstValidCyc < 0) begin
                firstValidCyc  = cycNo;
                firstValidData = busA.m_data;
            end
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
        end else begin
            runLen = 0;
        end

        planPop = pop;
        planRd  = expRd;
        planClr = (busA.cnt_clr === 1'b1);
        cycNo++;
    endtask

    // Advances the model across the edge just taken and drives the next cycle's inputs.
    task automatic applyStimulus();
        logic [31:0] w;
        if (rstN !== 1'b1) begin
            advQ.delete();
            mInflight = 1'b0;
            cntA = 0;
            cntB = 0;
        end else begin
            if (planPop) void'(advQ.pop_front());
            mInflight = planRd;
            if (planRd && srcQ.size() > 0) begin
                w = srcQ.pop_front();
                advQ.push_back(w);
                busA.fifo_r_data = w;
            end
            if (planClr) begin
                cntA = 0;
                cntB = 0;
            end else if (planPop) begin
                if (cntA < 65535) cntA++;
                if (cntB < 15) cntB++;
            end
        end
        gapPhase = !gapPhase;
        busA.fifo_empty = (srcQ.size() == 0) || (gapMode && gapPhase);
        case (readyMode)
            0:       busA.m_ready = 1'b0;
            1:       busA.m_ready = 1'b1;
            default: busA.m_ready = 1'($urandom_range(0, 1));
        endcase
        busA.cnt_clr = clrReq;
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic clearCnt();
        clrReq = 1'b1;
        cycle();
        clrReq = 1'b0;
        cycle();
    endtask

    initial begin
        busA.fifo_empty  = 1'b0;
        busA.fifo_r_data = '0;
        busA.m_ready     = 1'b1;
        busA.cnt_clr     = 1'b0;
        srcQ.push_back(32'hA5A5_0001);

        // Reset held with a non-empty FIFO: no read may be issued.
        repeat (3) cycle();
        #3;
        check("reset_rd_en", 32'(busA.fifo_rd_en), 32'd0);
        check("reset_m_valid", 32'(busA.m_valid), 32'd0);
        check("reset_m_data", busA.m_data, 32'd0);
        check("reset_word_cnt", 32'(busA.word_cnt), 32'd0);

        rstN = 1'b1;
        rdPulses = 0;
        firstRdCyc = -1;
        firstValidCyc = -1;
        repeat (6) cycle();
        #3;
        check("single_rd_pulses", 32'(rdPulses), 32'd1);
        check("single_latency", 32'(firstValidCyc - firstRdCyc), 32'd2);
        check("single_data", firstValidData, 32'hA5A5_0001);
        check("single_word_cnt", 32'(busA.word_cnt), 32'd1);

        clearCnt();
        maxRun = 0;
        runLen = 0;
        for (int i = 0; i < 8; i++) srcQ.push_back(32'(i));
        repeat (14) cycle();
        #3;
        check("stream_run", 32'(maxRun), 32'd8);
        check("stream_word_cnt", 32'(busA.word_cnt), 32'd8);

        clearCnt();
        readyMode = 0;
        rdPulses = 0;
        for (int i = 0; i < 8; i++) srcQ.push_back(32'(i));
        repeat (10) cycle();
        #3;
        check("bp_rd_pulses", 32'(rdPulses), 32'd2);
        check("bp_m_data", busA.m_data, 32'd0);
        check("bp_m_valid", 32'(busA.m_valid), 32'd1);
        readyMode = 1;
        repeat (14) cycle();
        #3;
        check("bp_word_cnt", 32'(busA.word_cnt), 32'd8);
        check("bp_drained", 32'(busA.m_valid), 32'd0);

        gapMode = 1'b1;
        readyMode = 2;
        for (int i = 0; i < 40; i++) srcQ.push_back($urandom);
        for (int i = 0; i < 600 && (srcQ.size() + advQ.size()) > 0; i++) cycle();
        check("sparse_drain_timeout", 32'(srcQ.size() + advQ.size()), 32'd0);
        gapMode = 1'b0;
        readyMode = 1;
        repeat (3) cycle();

        clearCnt();
        for (int i = 0; i < 20; i++) srcQ.push_back(32'h1000 + 32'(i));
        repeat (30) cycle();
        #3;
        check("sat_word_cnt4", 32'(busB.word_cnt), 32'd15);
        check("sat_word_cnt16", 32'(busA.word_cnt), 32'd20);

        readyMode = 0;
        srcQ.push_back(32'hBEEF_0000);
        srcQ.push_back(32'hBEEF_0001);
        repeat (6) cycle();
        readyMode = 1;
        clrReq = 1'b1;
        cycle();
        clrReq = 1'b0;
        cycle();
        #3;
        check("clr_wins_cnt4", 32'(busB.word_cnt), 32'd0);
        check("clr_wins_cnt16", 32'(busA.word_cnt), 32'd0);
        readyMode = 0;
        cycle();
        #3;
        check("after_clr_cnt4", 32'(busB.word_cnt), 32'd1);
        check("after_clr_cnt16", 32'(busA.word_cnt), 32'd1);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
